// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: master clock rate, default half-periods and counter sizing.
// Used by clk_div and clk_div_stage (optional tick outputs via CLK_DIV_TICK_EN).
package stopwatch_pkg;

  localparam int CLK_FREQ_HZ        = 100000000;
  localparam int ONEHZ_HALF_DEFAULT = 50000000;
  localparam int TWOHZ_HALF_DEFAULT = 25000000;
  localparam int FAST_HALF_DEFAULT  = 50000;
  localparam int BLINK_HALF_DEFAULT = 12500000;

  // A half-period of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int half);
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/clk_div_stage.sv
// One half-period counter driving a registered 50%-duty square wave.
// With CLK_DIV_TICK_EN defined it also emits a one-cycle pulse on each rising edge.
module clk_div_stage
  import stopwatch_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef CLK_DIV_TICK_EN
  output logic tick_out,
`endif
  output logic sq_out
);

  localparam int W = cnt_width(HALF);
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] cnt_reg;
  logic         sq_reg;
  logic         wrap;

  assign wrap = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      sq_reg  <= 1'b0;
    end else if (wrap) begin
      cnt_reg <= '0;
      sq_reg  <= ~sq_reg;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign sq_out = sq_reg;

`ifdef CLK_DIV_TICK_EN
  logic tick_reg;

  // Pulses in the same cycle the square wave goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= wrap & ~sq_reg;
    end
  end

  assign tick_out = tick_reg;
`endif

endmodule

// File: rtl/clk_div.sv
// Stopwatch clock generator: four phase-aligned square waves derived from the master clock.
// Defining CLK_DIV_TICK_EN adds one-cycle rising-edge tick outputs for each wave.
module clk_div
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_HZ,
  parameter int ONEHZ_HALF = ONEHZ_HALF_DEFAULT,
  parameter int TWOHZ_HALF = TWOHZ_HALF_DEFAULT,
  parameter int FAST_HALF  = FAST_HALF_DEFAULT,
  parameter int BLINK_HALF = BLINK_HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
`ifdef CLK_DIV_TICK_EN
  output logic onehz_tick,
  output logic twohz_tick,
  output logic fast_tick,
  output logic blink_tick,
`endif
  output logic onehz_clk,
  output logic twohz_clk,
  output logic fast_clk,
  output logic blink_clk
);

  // Stage order: 0 onehz, 1 twohz, 2 fast, 3 blink.
  function automatic int half_of(input int idx);
    case (idx)
      0:       return ONEHZ_HALF;
      1:       return TWOHZ_HALF;
      2:       return FAST_HALF;
      default: return BLINK_HALF;
    endcase
  endfunction

  logic [3:0] sq;
`ifdef CLK_DIV_TICK_EN
  logic [3:0] tick;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stage
      clk_div_stage #(
        .HALF(half_of(gi))
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
`ifdef CLK_DIV_TICK_EN
        .tick_out(tick[gi]),
`endif
        .sq_out  (sq[gi])
      );
    end
  endgenerate

  assign onehz_clk = sq[0];
  assign twohz_clk = sq[1];
  assign fast_clk  = sq[2];
  assign blink_clk = sq[3];

`ifdef CLK_DIV_TICK_EN
  assign onehz_tick = tick[0];
  assign twohz_tick = tick[1];
  assign fast_tick  = tick[2];
  assign blink_tick = tick[3];
`endif

endmodule
